// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EXEC,
    ST_FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_BUSERR   = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

endpackage

// File: rtl/fetch_if.sv
// Request/grant/response instruction memory port.
interface fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/fetch_timer.sv
// Cycle counter bounding the time a fetch may spend in REQ+WAIT.
module fetch_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rstB,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires during the TIMEOUT_CYC-th counted cycle so the FSM leaves on that edge.
  assign expired = count_en && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage feeding rv32i_core: fetches the word at core_pc, then grants one execute cycle.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rstB,
  input  logic            run,
  input  logic [XLEN-1:0] core_pc,
  output logic [XLEN-1:0] core_inst,
  output logic            core_clkEn,
  fetch_if.master         mem,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] fault_pc,
  output logic [31:0]     inst_cnt
);
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] core_inst_q, core_inst_d;
  logic            core_clkEn_q, core_clkEn_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_cause_q, fault_cause_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [31:0]     inst_cnt_q, inst_cnt_d;
  logic            pc_misaligned;
  logic            tmr_clear, tmr_count_en, tmr_expired;

  assign pc_misaligned = (core_pc[1:0] != 2'b00);

  // core_pc only moves on the edge closing EXEC, so the address can follow it directly.
  assign mem.mem_addr = {core_pc[XLEN-1:2], 2'b00};
  assign mem.mem_req  = (state_q == ST_REQ) && !pc_misaligned;

  assign tmr_count_en = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign tmr_clear    = (state_d == ST_REQ) && (state_q != ST_REQ);

  fetch_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rstB     (rstB),
    .clear    (tmr_clear),
    .count_en (tmr_count_en),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    core_inst_d   = XLEN'(NOP_INST);
    fault_cause_d = fault_cause_q;
    fault_pc_d    = fault_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (pc_misaligned) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_MISALIGN;
          fault_pc_d    = core_pc;
        end else if (tmr_expired) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_TIMEOUT;
          fault_pc_d    = core_pc;
        end else if (mem.mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response in the expiry cycle still loses to the timeout.
        if (tmr_expired) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_TIMEOUT;
          fault_pc_d    = core_pc;
        end else if (mem.mem_rvalid && mem.mem_err) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_BUSERR;
          fault_pc_d    = core_pc;
        end else if (mem.mem_rvalid) begin
          state_d     = ST_EXEC;
          core_inst_d = mem.mem_rdata;
        end
      end
      ST_EXEC: begin
        state_d = run ? ST_REQ : ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    core_clkEn_d = (state_d == ST_EXEC);
    fault_d      = (state_d == ST_FAULT);
    inst_cnt_d   = inst_cnt_q + 32'(state_q == ST_EXEC);
  end

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state_q       <= ST_IDLE;
      core_inst_q   <= XLEN'(NOP_INST);
      core_clkEn_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= FC_NONE;
      fault_pc_q    <= '0;
      inst_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      core_inst_q   <= core_inst_d;
      core_clkEn_q  <= core_clkEn_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q    <= fault_pc_d;
      inst_cnt_q    <= inst_cnt_d;
    end
  end

  assign core_inst   = core_inst_q;
  assign core_clkEn  = core_clkEn_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign fault_pc    = fault_pc_q;
  assign inst_cnt    = inst_cnt_q;
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage directly upstream of `rv32i_core`. It takes the core's `pc` and fetches the instruction word over a request/grant/response memory port with variable latency. It then presents the word on the core's `inst_in` and pulses the core's `clkEn` for exactly one cycle per instruction. Outside that execute cycle it drives a NOP on `inst_in`, so stalls have no architectural side effects in the core.

## Interface
Parameters:
- `XLEN`, 32, data and address width
- `TIMEOUT_CYC`, 255, maximum cycles spent in REQ+WAIT before a timeout fault; must be ≥ 2

Ports:
- `clk`  in  1  single clock
- `rstB`  in  1  reset, asynchronous, active-low
- `run`  in  1  fetch enable; sampled only in IDLE and EXEC
- `core_pc`  in  XLEN  current PC from core (`pc`)
- `core_inst`  out  XLEN  instruction to core (`inst_in`)
- `core_clkEn`  out  1  one-cycle execute enable to core (`clkEn`)
- `mem_req`  out  1  fetch request
- `mem_addr`  out  XLEN  word address, `{core_pc[XLEN-1:2],2'b00}`
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  response valid
- `mem_rdata`  in  XLEN  response data
- `mem_err`  in  1  bus error, qualified by `mem_rvalid`
- `fault`  out  1  sticky fault flag
- `fault_cause`  out  2  01 misaligned PC, 10 bus error, 11 timeout
- `fault_pc`  out  XLEN  PC that caused the fault
- `inst_cnt`  out  32  count of executed instructions, wraps at 2^32

## Operation
- States: IDLE, REQ, WAIT, EXEC, FAULT.
- IDLE: `run`=1 → REQ; otherwise stay in IDLE.
- REQ:
  - `core_pc[1:0]`≠0 → FAULT with cause 01. `mem_req` is not asserted.
  - Otherwise `mem_req`=1 and `mem_addr` is held stable until `mem_gnt`=1, then → WAIT.
  - `mem_rvalid` in REQ is ignored.
- WAIT:
  - `mem_rvalid`=1 and `mem_err`=0 → latch `mem_rdata` into the instruction register, → EXEC.
  - `mem_rvalid`=1 and `mem_err`=1 → FAULT with cause 10.
- EXEC:
  - `core_clkEn`=1 for this one cycle; `core_inst` = latched word; `inst_cnt`+1.
  - Next state: `run`=1 → REQ, else → IDLE.
- FAULT:
  - Terminal until reset. `fault`=1, `core_clkEn`=0, `mem_req`=0.
  - `fault_cause` and `fault_pc` are captured on entry and then frozen.
- Timeout counter:
  - Cleared on entry to REQ; increments every cycle in REQ or WAIT.
  - Reaching `TIMEOUT_CYC` without leaving WAIT → FAULT with cause 11.
  - A response arriving in that same cycle loses to the timeout.
- `core_inst` = 32'h0000_0013 (`addi x0,x0,0`) in every state except EXEC.
- `core_pc` only changes on the edge closing EXEC, so `mem_addr` is combinational from `core_pc`. It is stable for the whole REQ/WAIT window.
- `run` deasserted during REQ/WAIT has no effect until the in-flight fetch has executed.

## Timing
- Reset values:
  - state IDLE
  - `core_clkEn`=0, `mem_req`=0, `core_inst`=32'h0000_0013
  - `fault`=0, `fault_cause`=0, `fault_pc`=0, `inst_cnt`=0
- The memory port must return a response no earlier than the cycle after `mem_gnt`. `mem_rvalid` coincident with `mem_gnt` is ignored.
- Best-case throughput: 1 instruction per 3 cycles (REQ with same-cycle `mem_gnt`, WAIT with `mem_rvalid`, EXEC).
- Each added grant-wait or response-wait cycle adds 1 cycle.
- First `core_clkEn` after reset with `run` held high: cycle 4 after release (IDLE, REQ, WAIT, EXEC), given zero-wait memory.
- Reset asserted mid-transaction forces IDLE immediately. A late `mem_rvalid` arriving in IDLE is discarded.
- `core_clkEn` is never high on two consecutive cycles.

## Structure
- `fetch_pkg`:
  - state enum `fetch_state_t`
  - `NOP_INST` = 32'h0000_0013
  - cause constants `FC_MISALIGN`, `FC_BUSERR`, `FC_TIMEOUT`
- One sub-module, `fetch_timer`:
  - Parameterised by `TIMEOUT_CYC`.
  - Inputs `clear` and `count_en`; output `expired`.
  - Asynchronous reset on `rstB`.
- The top level holds the FSM, the instruction register, the fault registers and `inst_cnt`.

## Test plan
- Zero-wait memory, `run`=1, PCs 0x0, 0x4, 0x8 → `core_clkEn` pulses on cycles 4, 7, 10; `core_inst` equals the fetched words on those cycles and NOP elsewhere; `inst_cnt`=3.
- `mem_gnt` delayed 3 cycles, `mem_rvalid` delayed 2 → `mem_req` and `mem_addr` stay stable throughout; EXEC arrives 5 cycles later than the zero-wait case.
- `core_pc`=0x0000_0006 → FAULT with cause 01 and `fault_pc`=0x6; `mem_req` never asserted.
- Response with `mem_err`=1 at PC 0x100 → `fault`=1, `fault_cause`=10, `fault_pc`=0x100; no `core_clkEn`.
- `TIMEOUT_CYC`=8 and no `mem_rvalid` → FAULT with cause 11 exactly 8 cycles after REQ entry.
- `rstB` pulsed low while in WAIT, followed by a late `mem_rvalid` → FSM in IDLE, outputs at reset values, `inst_cnt`=0, late response ignored.
